// File: rtl/scale_job_sequencer_if.sv
// Job-descriptor push channel and completion-record channel of scale_job_sequencer.
// The sequencer takes the slave side; the job source and record consumer take the master side.
interface scale_job_sequencer_if;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [31:0] job_src_width_i;
  logic [31:0] job_src_height_i;
  logic [31:0] job_src_addr_i;
  logic [31:0] job_dst_width_i;
  logic [31:0] job_dst_height_i;
  logic [31:0] job_dst_addr_i;

  logic        done_valid_o;
  logic        done_ready_i;
  logic [1:0]  done_status_o;
  logic [31:0] done_exit_o;
  logic [31:0] done_cycles_o;

  modport slave (
    input  job_valid_i, job_src_width_i, job_src_height_i, job_src_addr_i,
           job_dst_width_i, job_dst_height_i, job_dst_addr_i, done_ready_i,
    output job_ready_o, done_valid_o, done_status_o, done_exit_o, done_cycles_o
  );

  modport master (
    output job_valid_i, job_src_width_i, job_src_height_i, job_src_addr_i,
           job_dst_width_i, job_dst_height_i, job_dst_addr_i, done_ready_i,
    input  job_ready_o, done_valid_o, done_status_o, done_exit_o, done_cycles_o
  );
endinterface

// File: rtl/scale_job_sequencer.sv
// Queues image-scale job descriptors, launches them one at a time on the core wrapper
// and returns a completion record (status, exit code, cycle count) for each job.
module scale_job_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  scale_job_sequencer_if.slave job,
  output logic [31:0]          src_width_o,
  output logic [31:0]          src_height_o,
  output logic [31:0]          src_offset_addr_o,
  output logic [31:0]          src_image_size_o,
  output logic [31:0]          dst_width_o,
  output logic [31:0]          dst_height_o,
  output logic [31:0]          dst_offset_addr_o,
  output logic [31:0]          dst_image_size_o,
  output logic                 start_o,
  input  logic                 idle_i,
  input  logic [31:0]          exit_i,
  output logic                 busy_o,
  output logic                 halted_o
);

  localparam int unsigned   PTR_W        = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [31:0] src_width;
    logic [31:0] src_height;
    logic [31:0] src_addr;
    logic [31:0] dst_width;
    logic [31:0] dst_height;
    logic [31:0] dst_addr;
  } job_desc_t;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_REPORT} state_e;
  typedef enum logic [1:0] {ST_OK, ST_FINISH, ST_ERROR, ST_TIMEOUT} status_e;

  job_desc_t        fifo_mem [DEPTH];
  job_desc_t        head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  state_e      state_q, state_d;
  job_desc_t   geom_q, geom_d;
  logic [31:0] src_size_q, src_size_d, dst_size_q, dst_size_d;
  logic        start_q, start_d, busy_q, busy_d, halted_q, halted_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_valid_q, done_valid_d;
  status_e     done_status_q, done_status_d;
  logic [31:0] done_exit_q, done_exit_d, done_cycles_q, done_cycles_d;
  logic        complete;
  status_e     comp_status;

  assign job.job_ready_o = (count_q != CNT_FULL);
  assign push = job.job_valid_i && job.job_ready_o;
  assign pop  = (state_q == S_REPORT) && job.done_ready_i;
  assign head = fifo_mem[rd_ptr_q];

  // NOTE: descriptor storage is not reset; count_q alone says which entries hold valid data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{job.job_src_width_i, job.job_src_height_i, job.job_src_addr_i,
                              job.job_dst_width_i, job.job_dst_height_i, job.job_dst_addr_i};
    end
  end

  // NOTE: combinational blocks use blocking '=' with a default for every target first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // Completion priority: error exit, clean finish, timeout, then plain idle return.
  always_comb begin
    complete    = 1'b1;
    comp_status = ST_OK;
    if (exit_i > 32'd1)                               comp_status = ST_ERROR;
    else if (exit_i == 32'd1)                         comp_status = ST_FINISH;
    else if (cnt_q == TIMEOUT_LAST)                   comp_status = ST_TIMEOUT;
    else if ((state_q == S_WAIT_DONE) && idle_i)      comp_status = ST_OK;
    else                                              complete    = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    geom_d        = geom_q;
    src_size_d    = src_size_q;
    dst_size_d    = dst_size_q;
    start_d       = 1'b0;
    cnt_d         = cnt_q;
    halted_d      = halted_q;
    done_valid_d  = done_valid_q;
    done_status_d = done_status_q;
    done_exit_d   = done_exit_q;
    done_cycles_d = done_cycles_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !halted_q && idle_i) begin
          state_d    = S_LAUNCH;
          geom_d     = head;
          src_size_d = 32'(head.src_width * head.src_height);
          dst_size_d = 32'(head.dst_width * head.dst_height);
        end
      end
      S_LAUNCH: begin
        if (idle_i) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        if (complete) begin
          state_d       = S_REPORT;
          done_valid_d  = 1'b1;
          done_status_d = comp_status;
          done_exit_d   = exit_i;
          done_cycles_d = cnt_q;
          if ((comp_status == ST_ERROR) || (comp_status == ST_TIMEOUT)) halted_d = 1'b1;
        end else if ((state_q == S_WAIT_BUSY) && !idle_i) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_REPORT: begin
        if (job.done_ready_i) begin
          done_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      geom_q        <= '0;
      src_size_q    <= '0;
      dst_size_q    <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
      done_valid_q  <= 1'b0;
      done_status_q <= ST_OK;
      done_exit_q   <= '0;
      done_cycles_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      geom_q        <= geom_d;
      src_size_q    <= src_size_d;
      dst_size_q    <= dst_size_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
      done_valid_q  <= done_valid_d;
      done_status_q <= done_status_d;
      done_exit_q   <= done_exit_d;
      done_cycles_q <= done_cycles_d;
    end
  end

  assign src_width_o       = geom_q.src_width;
  assign src_height_o      = geom_q.src_height;
  assign src_offset_addr_o = geom_q.src_addr;
  assign src_image_size_o  = src_size_q;
  assign dst_width_o       = geom_q.dst_width;
  assign dst_height_o      = geom_q.dst_height;
  assign dst_offset_addr_o = geom_q.dst_addr;
  assign dst_image_size_o  = dst_size_q;
  assign start_o           = start_q;
  assign busy_o            = busy_q;
  assign halted_o          = halted_q;
  assign job.done_valid_o  = done_valid_q;
  assign job.done_status_o = done_status_q;
  assign job.done_exit_o   = done_exit_q;
  assign job.done_cycles_o = done_cycles_q;

endmodule
